// File: rtl/reg_bank_arbiter_if.sv
// Handshake bundle between two requesters and the shared register bank.
// master = requester side, slave = arbiter side.
interface reg_bank_arbiter_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          done_a;
  logic          done_b;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, gnt_b, done_a, done_b,
    input  rdata, busy
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, gnt_b, done_a, done_b,
    output rdata, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one small register bank between requesters A and B.
// Each transaction runs IDLE -> ACCESS -> DONE with all outputs registered.
module reg_bank_arbiter #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input logic               clk,
  input logic               rst,
  reg_bank_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          sel_b_q, sel_b_d;
  logic          prio_b_q, prio_b_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          done_a_q, done_a_d;
  logic          done_b_q, done_b_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] bank_q [DEPTH];
  logic [DW-1:0] bank_d [DEPTH];
  logic          win_b;

  // B wins when it is alone, or when both ask and the pointer names B
  assign win_b = bus.req_b & (~bus.req_a | prio_b_q);

  always_comb begin
    state_d  = state_q;
    sel_b_d  = sel_b_q;
    prio_b_d = prio_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    done_a_d = done_a_q;
    done_b_d = done_b_q;
    busy_d   = busy_q;
    bank_d   = bank_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          sel_b_d = win_b;
          we_d    = win_b ? bus.we_b    : bus.we_a;
          addr_d  = win_b ? bus.addr_b  : bus.addr_a;
          wdata_d = win_b ? bus.wdata_b : bus.wdata_a;
          gnt_a_d = ~win_b;
          gnt_b_d = win_b;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) bank_d[addr_q] = wdata_q;
        else      rdata_d        = bank_q[addr_q];
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        done_a_d = ~sel_b_q;
        done_b_d = sel_b_q;
        prio_b_d = ~sel_b_q;
        state_d  = DONE;
      end
      DONE: begin
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_b_q  <= 1'b0;
      prio_b_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sel_b_q  <= sel_b_d;
      prio_b_q <= prio_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q   <= busy_d;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, access, contention,
// priority, field stability and mid-transaction reset.
module tb_reg_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  reg_bank_arbiter_if #(.DW(4), .AW(2)) bus ();

  reg_bank_arbiter #(.DW(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit sb, input bit rq, input bit we,
                       input logic [1:0] a, input logic [3:0] wd);
    if (sb) begin
      bus.req_b = rq; bus.we_b = we; bus.addr_b = a; bus.wdata_b = wd;
    end else begin
      bus.req_a = rq; bus.we_a = we; bus.addr_a = a; bus.wdata_a = wd;
    end
  endtask

  // one full transaction from IDLE; samples 1 time unit after each edge
  task automatic issue(input bit sb, input bit we, input logic [1:0] a,
                       input logic [3:0] wd, output logic g, output logic d,
                       output logic [3:0] rd, output logic b);
    drive(sb, 1'b1, we, a, wd);
    @(posedge clk); #1;
    g = sb ? (bus.gnt_b & ~bus.gnt_a) : (bus.gnt_a & ~bus.gnt_b);
    drive(sb, 1'b0, we, a, wd);
    @(posedge clk); #1;
    d  = sb ? (bus.done_b & ~bus.done_a) : (bus.done_a & ~bus.done_b);
    rd = bus.rdata;
    @(posedge clk); #1;
    b = bus.busy | bus.done_a | bus.done_b | bus.gnt_a | bus.gnt_b;
  endtask

  task automatic test_reset();
    logic g, d, b;
    logic [3:0] rd;
    logic [8:0] outs;
    #1000;
    rst = 1'b0;
    #1;
    outs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.rdata};
    compared++;
    if (outs !== 9'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got %b want 000000000", outs);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 2'(i), 4'h0, g, d, rd, b);
      compared++;
      if (rd !== 4'h0) begin
        mismatched++;
        $display("FAIL reset_read%0d got %h want 0", i, rd);
      end
      compared++;
      if (b !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_idle%0d got %b want 0", i, b);
      end
    end
  endtask

  task automatic test_write_read();
    logic g, d, b;
    logic [3:0] rd;
    issue(1'b0, 1'b1, 2'd2, 4'b1010, g, d, rd, b);
    compared++;
    if ({g, d, b} !== 3'b110) begin
      mismatched++;
      $display("FAIL wr_handshake got gnt/done/busy %b want 110", {g, d, b});
    end
    issue(1'b0, 1'b0, 2'd2, 4'h0, g, d, rd, b);
    compared++;
    if ({g, d, b} !== 3'b110) begin
      mismatched++;
      $display("FAIL rd_handshake got gnt/done/busy %b want 110", {g, d, b});
    end
    compared++;
    if (rd !== 4'b1010) begin
      mismatched++;
      $display("FAIL rd_data got %h want a", rd);
    end
  endtask

  task automatic test_contention();
    logic g, d, b;
    logic [3:0] rd;
    logic [3:0] order;
    int n;
    bit both;
    order = '0;
    n = 0;
    both = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 4'h3);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.gnt_a & bus.gnt_b) both = 1'b1;
      if (bus.gnt_a | bus.gnt_b) begin
        if (n < 4) order[n] = bus.gnt_b;
        n++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    compared++;
    if (n != 4) begin
      mismatched++;
      $display("FAIL cont_count got %0d grants want 4", n);
    end
    compared++;
    if (order !== 4'b1010) begin
      mismatched++;
      $display("FAIL cont_order got %b (bit0 first, 1=B) want 1010", order);
    end
    compared++;
    if (both !== 1'b0) begin
      mismatched++;
      $display("FAIL cont_excl got both=%b want 0", both);
    end
    issue(1'b0, 1'b0, 2'd0, 4'h0, g, d, rd, b);
    compared++;
    if (rd !== 4'hF) begin
      mismatched++;
      $display("FAIL cont_rd0 got %h want f", rd);
    end
    issue(1'b0, 1'b0, 2'd1, 4'h0, g, d, rd, b);
    compared++;
    if (rd !== 4'h3) begin
      mismatched++;
      $display("FAIL cont_rd1 got %h want 3", rd);
    end
  endtask

  task automatic test_priority();
    logic g, d, b;
    logic [3:0] rd;
    issue(1'b1, 1'b0, 2'd1, 4'h0, g, d, rd, b);
    compared++;
    if ({g, d, rd} !== 6'b11_0011) begin
      mismatched++;
      $display("FAIL prio_b_alone got g/d/rd %b/%b/%h want 1/1/3", g, d, rd);
    end
    drive(1'b0, 1'b1, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h0);
    @(posedge clk); #1;
    compared++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      mismatched++;
      $display("FAIL prio_winner got gnt_a/b %b want 10", {bus.gnt_a, bus.gnt_b});
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    @(posedge clk); #1;
    compared++;
    if ({bus.done_a, bus.done_b} !== 2'b10) begin
      mismatched++;
      $display("FAIL prio_done got done_a/b %b want 10", {bus.done_a, bus.done_b});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_field_stability();
    logic g, d, b;
    logic [3:0] rd;
    issue(1'b1, 1'b1, 2'd3, 4'h5, g, d, rd, b);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 4'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    @(posedge clk); #1;
    compared++;
    if (bus.done_a !== 1'b1) begin
      mismatched++;
      $display("FAIL stab_done got %b want 1", bus.done_a);
    end
    compared++;
    if (bus.rdata !== 4'h5) begin
      mismatched++;
      $display("FAIL stab_rdata got %h want 5", bus.rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic g, d, b;
    logic [3:0] rd;
    logic [8:0] outs;
    bit saw_done;
    saw_done = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'd1, 4'hC);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    rst = 1'b1;
    #1;
    outs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.rdata};
    compared++;
    if (outs !== 9'd0) begin
      mismatched++;
      $display("FAIL rstmid_outputs got %b want 000000000", outs);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done_b | bus.done_a) saw_done = 1'b1;
    end
    compared++;
    if (saw_done !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_nodone got %b want 0", saw_done);
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_idle got busy %b want 0", bus.busy);
    end
    issue(1'b0, 1'b0, 2'd1, 4'h0, g, d, rd, b);
    compared++;
    if ({d, rd} !== 5'b1_0000) begin
      mismatched++;
      $display("FAIL rstmid_rd got done/rd %b/%h want 1/0", d, rd);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    test_reset();
    test_write_read();
    test_contention();
    test_priority();
    test_field_stability();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
